// File: rtl/out_fifo_pkg.sv
// rtl/out_fifo_pkg.sv - shared widths for the core output/input side buffers
package out_fifo_pkg;

    // Address field width; a single-address port still needs one bit.
    function automatic int addr_w(input int nuioou);
        return ($clog2(nuioou) > 1) ? $clog2(nuioou) : 1;
    endfunction

    // Floating-point word width: sign + exponent + mantissa.
    function automatic int data_w(input int nbmant, input int nbexpo);
        return nbmant + nbexpo + 1;
    endfunction

    // One stored entry is {addr, data}.
    function automatic int entry_w(input int nbmant, input int nbexpo, input int nuioou);
        return data_w(nbmant, nbexpo) + addr_w(nuioou);
    endfunction

    // Pointers wrap modulo depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count must reach depth itself, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - register array with one write port and an asynchronous read port
module fifo_ram
    import out_fifo_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed word changes on a write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array storage; cleared on reset so the stale head reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - core output write buffer with valid/ready drain and sticky overflow
module out_fifo
    import out_fifo_pkg::*;
#(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [data_w(NBMANT, NBEXPO)-1:0]   data_in,
    input  logic [addr_w(NUIOOU)-1:0]           addr_in,
    input  logic                                out_en,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [data_w(NBMANT, NBEXPO)-1:0]   out_data,
    output logic [addr_w(NUIOOU)-1:0]           out_addr,
    output logic [cnt_w(FDEPTH)-1:0]            count,
    output logic                                full,
    output logic                                empty,
    output logic                                ovf,
    input  logic                                ovf_clr
);

    localparam int DW = data_w(NBMANT, NBEXPO);
    localparam int EW = entry_w(NBMANT, NBEXPO, NUIOOU);
    localparam int PW = ptr_w(FDEPTH);
    localparam int CW = cnt_w(FDEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          wr_en, rd_en;
    logic [EW-1:0] head;

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign out_valid = !empty;
    assign count     = cnt_q;
    assign ovf       = ovf_q;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_en = out_valid && out_ready;
    assign wr_en = out_en && (!full || rd_en);

    // Pointer, count and overflow next-state; overflow set beats clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (out_en && !wr_en) begin
            ovf_d = 1'b1;
        end
    end

    // Control state register; reset drops every held entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    fifo_ram #(
        .WIDTH (EW),
        .DEPTH (FDEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({addr_in, data_in}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign out_data = head[DW-1:0];
    assign out_addr = head[EW-1:DW];

endmodule
